// File: rtl/dep_wakeup_sched.sv
// Dependency wakeup scheduler: per-slot dependency rows cleared by completions; one ready slot offered per cycle.
// Optional DEP_SCHED_OLDEST_FIRST_EN selects the oldest ready slot through an age matrix instead of the lowest index.
//
// slot state (occ,iss,dep) | meaning
// FREE    (0,0,-)          | slot unused
// WAIT    (1,0,!=0)        | allocated, waiting on producers
// READY   (1,0,==0)        | allocated, eligible for issue
// ISSUED  (1,1,-)          | accepted by execute, waiting for done
module dep_wakeup_sched #(
   parameter int bs = 16,
   localparam int IW = $clog2(bs)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alloc_valid,
   input  logic [IW-1:0] alloc_index,
   input  logic [bs-1:0] alloc_dep,
   output logic          issue_valid,
   output logic [IW-1:0] issue_index,
   input  logic          issue_ready,
   input  logic          done_valid,
   input  logic [IW-1:0] done_index,
   output logic [bs-1:0] pending,
   output logic [IW:0]   occupancy,
   output logic          full,
   output logic          empty,
   output logic          err
);

   localparam logic [bs-1:0] one_hot0 = bs'(1);

   logic [bs-1:0]          occ, occ_nxt, iss, iss_nxt, ready;
   logic [bs-1:0]          done_mask, self_mask;
   logic [bs-1:0][bs-1:0]  dep, dep_nxt;
   logic [IW:0]            occ_cnt, occ_cnt_nxt;
   logic                   err_q, err_nxt, done_ok, alloc_ok, issue_fire;

`ifdef DEP_SCHED_OLDEST_FIRST_EN
   // age[k][j]=1: slot j was already occupied when slot k was allocated
   logic [bs-1:0][bs-1:0]  age, age_nxt;
`endif

   always_comb begin
      for (int k = 0; k < bs; k++)
         ready[k] = occ[k] & ~iss[k] & ~(|dep[k]);
   end

   always_comb begin
      issue_valid = |ready;
      issue_index = '0;
`ifdef DEP_SCHED_OLDEST_FIRST_EN
      for (int k = 0; k < bs; k++)
         if (ready[k] && ((age[k] & ready) == '0))
            issue_index = IW'(k);
`else
      for (int k = bs - 1; k >= 0; k--)
         if (ready[k])
            issue_index = IW'(k);
`endif
   end

   always_comb begin
      done_ok    = done_valid & occ[done_index] & iss[done_index];
      done_mask  = done_ok ? (one_hot0 << done_index) : '0;
      self_mask  = one_hot0 << alloc_index;
      // a slot being freed by done this cycle may be re-allocated in the same cycle
      alloc_ok   = alloc_valid & ~(occ[alloc_index] & ~done_mask[alloc_index]);
      issue_fire = issue_valid & issue_ready;

      occ_nxt = occ & ~done_mask;
      iss_nxt = iss & ~done_mask;
      for (int k = 0; k < bs; k++)
         dep_nxt[k] = dep[k] & ~done_mask;
      if (issue_fire)
         iss_nxt[issue_index] = 1'b1;
      if (alloc_ok) begin
         occ_nxt = occ_nxt | self_mask;
         iss_nxt = iss_nxt & ~self_mask;
         dep_nxt[alloc_index] = alloc_dep & occ & ~self_mask & ~done_mask;
      end

      occ_cnt_nxt = occ_cnt + {{IW{1'b0}}, alloc_ok} - {{IW{1'b0}}, done_ok};
      err_nxt     = err_q | (done_valid & ~done_ok) | (alloc_valid & ~alloc_ok);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ     <= '0;
         iss     <= '0;
         dep     <= '0;
         occ_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         occ     <= occ_nxt;
         iss     <= iss_nxt;
         dep     <= dep_nxt;
         occ_cnt <= occ_cnt_nxt;
         err_q   <= err_nxt;
      end
   end

`ifdef DEP_SCHED_OLDEST_FIRST_EN
   // a re-allocated slot becomes younger than every other occupant
   always_comb begin
      age_nxt = age;
      if (alloc_ok) begin
         for (int k = 0; k < bs; k++)
            age_nxt[k][alloc_index] = 1'b0;
         age_nxt[alloc_index] = occ & ~done_mask & ~self_mask;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) age <= '0;
      else     age <= age_nxt;
   end
`endif

   assign pending   = occ;
   assign occupancy = occ_cnt;
   assign full      = (occ_cnt == (IW+1)'(bs));
   assign empty     = (occ_cnt == '0);
   assign err       = err_q;

endmodule

// File: tb/tb_dep_wakeup_sched.sv
// Scoreboard bench for dep_wakeup_sched: expected issue order queued at alloc time, popped at each accepted handshake.
module tb_dep_wakeup_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_valid;
   logic [3:0]  alloc_index;
   logic [15:0] alloc_dep;
   logic        issue_valid;
   logic [3:0]  issue_index;
   logic        issue_ready;
   logic        done_valid;
   logic [3:0]  done_index;
   logic [15:0] pending;
   logic [4:0]  occupancy;
   logic        full, empty, err;

   int vecs = 0;
   int miss = 0;
   int exp_q[$];

   dep_wakeup_sched #(.bs(16)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_index(alloc_index), .alloc_dep(alloc_dep),
      .issue_valid(issue_valid), .issue_index(issue_index), .issue_ready(issue_ready),
      .done_valid(done_valid), .done_index(done_index),
      .pending(pending), .occupancy(occupancy), .full(full), .empty(empty), .err(err)
   );

   always #5 clk = ~clk;

   // inputs are driven 1 time unit after a rising edge; outputs are checked there too
   task automatic step();
      @(posedge clk);
      #1;
      alloc_valid = 1'b0;
      done_valid  = 1'b0;
      issue_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      alloc_valid = 1'b0; alloc_index = '0; alloc_dep = '0;
      done_valid = 1'b0; done_index = '0; issue_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic alloc(input int idx, input logic [15:0] d, input bit expect_issue);
      alloc_valid = 1'b1;
      alloc_index = 4'(idx);
      alloc_dep   = d;
      if (expect_issue) exp_q.push_back(idx);
   endtask

   task automatic done(input int idx);
      done_valid = 1'b1;
      done_index = 4'(idx);
   endtask

   // offer check + accept: pops the scoreboard and compares the offered slot
   task automatic accept(input string name);
      int e;
      vecs++;
      if (exp_q.size() == 0) begin
         miss++;
         $display("FAIL %s scoreboard empty, issue_valid=%0d issue_index=%0d", name, issue_valid, issue_index);
      end else begin
         e = exp_q.pop_front();
         if (issue_valid !== 1'b1 || issue_index !== 4'(e)) begin
            miss++;
            $display("FAIL %s got valid=%0d index=%0d, need valid=1 index=%0d", name, issue_valid, issue_index, e);
         end
      end
      issue_ready = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      alloc(3, 16'h0, 1'b0);
      step();
      alloc(5, 16'h0, 1'b0);
      step();
      #2 rst = 1'b1;
      #1;
      vecs++;
      if (pending !== 16'h0 || occupancy !== 5'd0 || issue_valid !== 1'b0) begin
         miss++;
         $display("FAIL async_reset pending=%h occ=%0d iv=%0d, need 0/0/0", pending, occupancy, issue_valid);
      end
      step();
      rst = 1'b0;
      step();
      vecs++;
      if (pending !== 16'h0 || occupancy !== 5'd0 || empty !== 1'b1 || full !== 1'b0 ||
          issue_valid !== 1'b0 || issue_index !== 4'd0 || err !== 1'b0) begin
         miss++;
         $display("FAIL reset_state pending=%h occ=%0d empty=%0d full=%0d iv=%0d ii=%0d err=%0d, need 0 0 1 0 0 0 0",
                  pending, occupancy, empty, full, issue_valid, issue_index, err);
      end
   endtask

   task automatic test_independent();
      do_reset();
      alloc(3, 16'h0, 1'b1);
      vecs++;
      if (issue_valid !== 1'b0) begin
         miss++;
         $display("FAIL indep_early issue_valid=%0d need 0", issue_valid);
      end
      step();
      vecs++;
      if (occupancy !== 5'd1 || pending !== 16'h0008 || empty !== 1'b0) begin
         miss++;
         $display("FAIL indep_occ occ=%0d pending=%h empty=%0d need 1 0008 0", occupancy, pending, empty);
      end
      accept("indep_issue");
      step();
      vecs++;
      if (issue_valid !== 1'b0) begin
         miss++;
         $display("FAIL indep_after_accept issue_valid=%0d need 0", issue_valid);
      end
      done(3);
      step();
      vecs++;
      if (occupancy !== 5'd0 || empty !== 1'b1 || err !== 1'b0) begin
         miss++;
         $display("FAIL indep_done occ=%0d empty=%0d err=%0d need 0 1 0", occupancy, empty, err);
      end
   endtask

   task automatic test_chain();
      do_reset();
      alloc(2, 16'h0, 1'b1);
      step();
      alloc(5, 16'h0004, 1'b1);
      step();
      accept("chain_issue2");
      step();
      vecs++;
      if (issue_valid !== 1'b0) begin
         miss++;
         $display("FAIL chain_wait issue_valid=%0d need 0", issue_valid);
      end
      done(2);
      step();
      accept("chain_wakeup5");
      step();
      // self bit 7 and free slot 8 must be dropped
      alloc(7, 16'h0180, 1'b1);
      step();
      vecs++;
      if (pending !== 16'h00A0 || occupancy !== 5'd2) begin
         miss++;
         $display("FAIL chain_pending pending=%h occ=%0d need 00a0 2", pending, occupancy);
      end
      accept("chain_selfdep7");
      step();
      vecs++;
      if (err !== 1'b0) begin
         miss++;
         $display("FAIL chain_err err=%0d need 0", err);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      alloc(4, 16'h0, 1'b1);
      step();
      accept("same_issue4");
      step();
      done(4);
      alloc(9, 16'h0010, 1'b1);
      step();
      vecs++;
      if (occupancy !== 5'd1 || pending !== 16'h0200 || err !== 1'b0) begin
         miss++;
         $display("FAIL same_done_alloc occ=%0d pending=%h err=%0d need 1 0200 0", occupancy, pending, err);
      end
      accept("same_ready9");
      alloc(4, 16'h0, 1'b1);
      step();
      accept("same_issue4b");
      step();
      done(4);
      alloc(4, 16'h0, 1'b1);
      step();
      vecs++;
      if (occupancy !== 5'd2 || pending !== 16'h0210 || err !== 1'b0) begin
         miss++;
         $display("FAIL same_index occ=%0d pending=%h err=%0d need 2 0210 0", occupancy, pending, err);
      end
      accept("same_realloc4");
      step();
   endtask

   task automatic test_errors();
      do_reset();
      alloc(6, 16'h0, 1'b1);
      step();
      alloc(6, 16'h0001, 1'b0);
      step();
      vecs++;
      if (err !== 1'b1 || occupancy !== 5'd1 || pending !== 16'h0040) begin
         miss++;
         $display("FAIL err_alloc_occupied err=%0d occ=%0d pending=%h need 1 1 0040", err, occupancy, pending);
      end
      done(6);
      step();
      vecs++;
      if (err !== 1'b1 || occupancy !== 5'd1 || issue_valid !== 1'b1) begin
         miss++;
         $display("FAIL err_done_unissued err=%0d occ=%0d iv=%0d need 1 1 1", err, occupancy, issue_valid);
      end
      accept("err_slot_still_ready");
      step();
      done(6);
      step();
      repeat (3) step();
      vecs++;
      if (err !== 1'b1 || occupancy !== 5'd0) begin
         miss++;
         $display("FAIL err_sticky err=%0d occ=%0d need 1 0", err, occupancy);
      end
      do_reset();
      vecs++;
      if (err !== 1'b0) begin
         miss++;
         $display("FAIL err_clear err=%0d need 0", err);
      end
   endtask

   task automatic test_priority();
      int budget;
      do_reset();
      alloc(8, 16'h0, 1'b0);
      step();
      alloc(1, 16'h0, 1'b0);
      step();
      step();
      vecs++;
`ifdef DEP_SCHED_OLDEST_FIRST_EN
      if (issue_index !== 4'd8 || issue_valid !== 1'b1) begin
         miss++;
         $display("FAIL prio_oldest index=%0d iv=%0d need 8 1", issue_index, issue_valid);
      end
`else
      if (issue_index !== 4'd1 || issue_valid !== 1'b1) begin
         miss++;
         $display("FAIL prio_lowest index=%0d iv=%0d need 1 1", issue_index, issue_valid);
      end
`endif
      for (int i = 0; i < 16; i++) begin
         if (i != 1 && i != 8) begin
            alloc(i, 16'h0, 1'b0);
            step();
         end
      end
      vecs++;
      if (full !== 1'b1 || occupancy !== 5'd16 || pending !== 16'hFFFF || empty !== 1'b0) begin
         miss++;
         $display("FAIL prio_full full=%0d occ=%0d pending=%h need 1 16 ffff", full, occupancy, pending);
      end
`ifdef DEP_SCHED_OLDEST_FIRST_EN
      exp_q.push_back(8);
      exp_q.push_back(1);
      for (int i = 0; i < 16; i++)
         if (i != 1 && i != 8) exp_q.push_back(i);
`else
      for (int i = 0; i < 16; i++) exp_q.push_back(i);
`endif
      budget = 40;
      while (exp_q.size() != 0 && budget > 0) begin
         accept("prio_drain");
         step();
         budget--;
      end
      vecs++;
      if (exp_q.size() != 0 || issue_valid !== 1'b0) begin
         miss++;
         $display("FAIL prio_drain_end left=%0d iv=%0d need 0 0", exp_q.size(), issue_valid);
      end
   endtask

   initial begin
      test_reset();
      test_independent();
      test_chain();
      test_same_cycle();
      test_errors();
      test_priority();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

endmodule
